// File: rtl/qft_stage_sched.sv
// Butterfly-stage sequencer: issues N/2 read pairs, delays them PIPE_LAT cycles for write-back, pulses done.
// Issue starts on the accepting edge; hold inserts bubbles that travel down the delay line.
// Back-pressure: hold only; start while busy is ignored.
module qft_stage_sched #(
  parameter int LOG2N    = 4,
  parameter int PIPE_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LOG2N-1:0] stage,
  input  logic             hold,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b
);

  localparam logic [LOG2N-1:0] ONE    = LOG2N'(1);
  localparam logic [LOG2N-1:0] K_LAST = LOG2N'((1 << (LOG2N - 1)) - 1);
  localparam logic [LOG2N-1:0] STAGES = LOG2N'(LOG2N);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;
  logic [LOG2N-1:0] k_q, k_d, s_q, s_d;
  logic rd_en_q, rd_en_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [LOG2N-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d;
  logic [PIPE_LAT-1:0] dl_v_q, dl_v_d;
  logic [PIPE_LAT-1:0][LOG2N-1:0] dl_a_q, dl_a_d, dl_b_q, dl_b_d;
  logic [PIPE_LAT:0] pend_v;
  logic pending, issue;
  logic [LOG2N-1:0] sel_k, sel_s, half, lo;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    s_d     = s_q;
    rd_en_d = 1'b0;
    rd_a_d  = rd_a_q;
    rd_b_d  = rd_b_q;
    err_d   = 1'b0;
    issue   = 1'b0;
    sel_k   = k_q;

    // Pairs still upstream of the write-back register; the output stage itself is excluded
    // so done lands the cycle after the last wr_en.
    pend_v  = {dl_v_q, rd_en_q};
    pending = |pend_v[PIPE_LAT-1:0];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (stage < STAGES) begin
            s_d     = stage;
            issue   = 1'b1;
            sel_k   = '0;
            k_d     = ONE;
            state_d = (K_LAST == '0) ? S_DRAIN : S_ISSUE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (!hold) begin
          issue = 1'b1;
          k_d   = k_q + ONE;
          if (k_q == K_LAST) begin
            k_d     = '0;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!pending) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    sel_s = s_d;
    half  = ONE << sel_s;
    lo    = ((sel_k >> sel_s) << (sel_s + ONE)) | (sel_k & (half - ONE));
    if (issue) begin
      rd_en_d = 1'b1;
      rd_a_d  = lo;
      rd_b_d  = lo + half;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);

    dl_v_d = PIPE_LAT'({dl_v_q, rd_en_q});
    dl_a_d = (PIPE_LAT * LOG2N)'({dl_a_q, rd_a_q});
    dl_b_d = (PIPE_LAT * LOG2N)'({dl_b_q, rd_b_q});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      s_q     <= '0;
      rd_en_q <= 1'b0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      dl_v_q  <= '0;
      dl_a_q  <= '0;
      dl_b_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      s_q     <= s_d;
      rd_en_q <= rd_en_d;
      rd_a_q  <= rd_a_d;
      rd_b_q  <= rd_b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      dl_v_q  <= dl_v_d;
      dl_a_q  <= dl_a_d;
      dl_b_q  <= dl_b_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rd_en     = rd_en_q;
  assign rd_addr_a = rd_a_q;
  assign rd_addr_b = rd_b_q;
  assign wr_en     = dl_v_q[PIPE_LAT-1];
  assign wr_addr_a = dl_a_q[PIPE_LAT-1];
  assign wr_addr_b = dl_b_q[PIPE_LAT-1];

endmodule

// File: tb/tb_qft_stage_sched.sv
// Directed bench for qft_stage_sched with LOG2N=3, PIPE_LAT=2.
// Cycle c is the output window just after the c-th edge of a scenario; inputs are set before that edge.
module tb_qft_stage_sched;

  logic clk = 1'b0;
  logic rst, start, hold;
  logic [2:0] stage;
  logic busy, done, err, rd_en, wr_en;
  logic [2:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  int checks = 0;
  int errors = 0;

  qft_stage_sched #(.LOG2N(3), .PIPE_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .stage(stage), .hold(hold),
    .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; hold = 1'b0; stage = '0;
    repeat (3) @(posedge clk);
    #1;
    checks += 6;
    if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    if (err !== 1'b0)       begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    if (rd_en !== 1'b0)     begin errors++; $display("FAIL reset_rd_en got %b exp 0", rd_en); end
    if (wr_en !== 1'b0)     begin errors++; $display("FAIL reset_wr_en got %b exp 0", wr_en); end
    if (rd_addr_b !== 3'd0) begin errors++; $display("FAIL reset_rd_addr_b got %0d exp 0", rd_addr_b); end
    rst = 1'b0;
  endtask

  // One unheld run; pair tables packed with pair 0 in the low 3 bits.
  task automatic test_pairs(input logic [2:0] stg, input logic [11:0] lo12, input logic [11:0] hi12);
    logic e_rd, e_wr, e_done, e_busy;
    for (int c = 1; c <= 10; c++) begin
      start = (c == 1); stage = stg;
      @(posedge clk); #1;
      e_rd = (c >= 1 && c <= 4); e_wr = (c >= 3 && c <= 6);
      e_done = (c == 7); e_busy = (c <= 7);
      checks += 4;
      if (rd_en !== e_rd)  begin errors++; $display("FAIL pairs_s%0d_rd_en c=%0d got %b exp %b", stg, c, rd_en, e_rd); end
      if (wr_en !== e_wr)  begin errors++; $display("FAIL pairs_s%0d_wr_en c=%0d got %b exp %b", stg, c, wr_en, e_wr); end
      if (done !== e_done) begin errors++; $display("FAIL pairs_s%0d_done c=%0d got %b exp %b", stg, c, done, e_done); end
      if (busy !== e_busy) begin errors++; $display("FAIL pairs_s%0d_busy c=%0d got %b exp %b", stg, c, busy, e_busy); end
      if (e_rd) begin
        checks += 2;
        if (rd_addr_a !== lo12[3*(c-1) +: 3]) begin errors++; $display("FAIL pairs_s%0d_rd_a c=%0d got %0d exp %0d", stg, c, rd_addr_a, lo12[3*(c-1) +: 3]); end
        if (rd_addr_b !== hi12[3*(c-1) +: 3]) begin errors++; $display("FAIL pairs_s%0d_rd_b c=%0d got %0d exp %0d", stg, c, rd_addr_b, hi12[3*(c-1) +: 3]); end
      end
      if (e_wr) begin
        checks += 2;
        if (wr_addr_a !== lo12[3*(c-3) +: 3]) begin errors++; $display("FAIL pairs_s%0d_wr_a c=%0d got %0d exp %0d", stg, c, wr_addr_a, lo12[3*(c-3) +: 3]); end
        if (wr_addr_b !== hi12[3*(c-3) +: 3]) begin errors++; $display("FAIL pairs_s%0d_wr_b c=%0d got %0d exp %0d", stg, c, wr_addr_b, hi12[3*(c-3) +: 3]); end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_hold();
    logic [12:1] erd   = 12'b000000111001;
    logic [12:1] ewr   = 12'b000011100100;
    logic [12:1] edone = 12'b000100000000;
    logic [12:1] ebusy = 12'b000111111111;
    logic [11:0] lo12  = {3'd5, 3'd4, 3'd1, 3'd0};
    logic [11:0] hi12  = {3'd7, 3'd6, 3'd3, 3'd2};
    int ri = 0;
    int wi = 0;
    for (int c = 1; c <= 12; c++) begin
      start = (c == 1); stage = 3'd1; hold = (c == 2 || c == 3);
      @(posedge clk); #1;
      checks += 4;
      if (rd_en !== erd[c])   begin errors++; $display("FAIL hold_rd_en c=%0d got %b exp %b", c, rd_en, erd[c]); end
      if (wr_en !== ewr[c])   begin errors++; $display("FAIL hold_wr_en c=%0d got %b exp %b", c, wr_en, ewr[c]); end
      if (done !== edone[c])  begin errors++; $display("FAIL hold_done c=%0d got %b exp %b", c, done, edone[c]); end
      if (busy !== ebusy[c])  begin errors++; $display("FAIL hold_busy c=%0d got %b exp %b", c, busy, ebusy[c]); end
      if (rd_en === 1'b1 && ri < 4) begin
        checks += 2;
        if (rd_addr_a !== lo12[3*ri +: 3]) begin errors++; $display("FAIL hold_rd_a c=%0d got %0d exp %0d", c, rd_addr_a, lo12[3*ri +: 3]); end
        if (rd_addr_b !== hi12[3*ri +: 3]) begin errors++; $display("FAIL hold_rd_b c=%0d got %0d exp %0d", c, rd_addr_b, hi12[3*ri +: 3]); end
      end
      if (rd_en === 1'b1) ri++;
      if (wr_en === 1'b1 && wi < 4) begin
        checks += 2;
        if (wr_addr_a !== lo12[3*wi +: 3]) begin errors++; $display("FAIL hold_wr_a c=%0d got %0d exp %0d", c, wr_addr_a, lo12[3*wi +: 3]); end
        if (wr_addr_b !== hi12[3*wi +: 3]) begin errors++; $display("FAIL hold_wr_b c=%0d got %0d exp %0d", c, wr_addr_b, hi12[3*wi +: 3]); end
      end
      if (wr_en === 1'b1) wi++;
    end
    start = 1'b0; hold = 1'b0;
    checks += 2;
    if (ri != 4) begin errors++; $display("FAIL hold_rd_count got %0d exp 4", ri); end
    if (wi != 4) begin errors++; $display("FAIL hold_wr_count got %0d exp 4", wi); end
  endtask

  task automatic test_err();
    for (int c = 1; c <= 3; c++) begin
      start = (c == 1); stage = 3'd3;
      @(posedge clk); #1;
      checks += 4;
      if (err !== (c == 1)) begin errors++; $display("FAIL err_pulse c=%0d got %b exp %b", c, err, (c == 1)); end
      if (busy !== 1'b0)    begin errors++; $display("FAIL err_busy c=%0d got %b exp 0", c, busy); end
      if (rd_en !== 1'b0)   begin errors++; $display("FAIL err_rd_en c=%0d got %b exp 0", c, rd_en); end
      if (wr_en !== 1'b0)   begin errors++; $display("FAIL err_wr_en c=%0d got %b exp 0", c, wr_en); end
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int c = 1; c <= 10; c++) begin
      start = (c == 1); stage = 3'd1; rst = (c == 3);
      @(posedge clk); #1;
      checks += 5;
      if (rd_en !== (c <= 2)) begin errors++; $display("FAIL rstmid_rd_en c=%0d got %b exp %b", c, rd_en, (c <= 2)); end
      if (busy !== (c <= 2))  begin errors++; $display("FAIL rstmid_busy c=%0d got %b exp %b", c, busy, (c <= 2)); end
      if (wr_en !== 1'b0)     begin errors++; $display("FAIL rstmid_wr_en c=%0d got %b exp 0", c, wr_en); end
      if (done !== 1'b0)      begin errors++; $display("FAIL rstmid_done c=%0d got %b exp 0", c, done); end
      if (err !== 1'b0)       begin errors++; $display("FAIL rstmid_err c=%0d got %b exp 0", c, err); end
      if (c == 3) begin
        checks += 2;
        if (rd_addr_a !== 3'd0) begin errors++; $display("FAIL rstmid_rd_a got %0d exp 0", rd_addr_a); end
        if (rd_addr_b !== 3'd0) begin errors++; $display("FAIL rstmid_rd_b got %0d exp 0", rd_addr_b); end
      end
    end
    start = 1'b0; rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [20:1] erd   = 20'b1111_0000_1111_0000_1111;
    logic [20:1] ewr   = 20'b1100_0011_1100_0011_1100;
    logic [20:1] edone = 20'b0000_0100_0000_0100_0000;
    logic [20:1] ebusy = 20'b1111_0111_1111_0111_1111;
    int ndone = 0;
    for (int c = 1; c <= 20; c++) begin
      start = 1'b1; stage = 3'd2;
      @(posedge clk); #1;
      checks += 5;
      if (rd_en !== erd[c])  begin errors++; $display("FAIL b2b_rd_en c=%0d got %b exp %b", c, rd_en, erd[c]); end
      if (wr_en !== ewr[c])  begin errors++; $display("FAIL b2b_wr_en c=%0d got %b exp %b", c, wr_en, ewr[c]); end
      if (done !== edone[c]) begin errors++; $display("FAIL b2b_done c=%0d got %b exp %b", c, done, edone[c]); end
      if (busy !== ebusy[c]) begin errors++; $display("FAIL b2b_busy c=%0d got %b exp %b", c, busy, ebusy[c]); end
      if (err !== 1'b0)      begin errors++; $display("FAIL b2b_err c=%0d got %b exp 0", c, err); end
      if (done === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 2) begin errors++; $display("FAIL b2b_done_count got %0d exp 2", ndone); end
    start = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pairs(3'd1, {3'd5, 3'd4, 3'd1, 3'd0}, {3'd7, 3'd6, 3'd3, 3'd2});
    test_pairs(3'd0, {3'd6, 3'd4, 3'd2, 3'd0}, {3'd7, 3'd5, 3'd3, 3'd1});
    test_pairs(3'd2, {3'd3, 3'd2, 3'd1, 3'd0}, {3'd7, 3'd6, 3'd5, 3'd4});
    test_hold();
    test_err();
    test_pairs(3'd1, {3'd5, 3'd4, 3'd1, 3'd0}, {3'd7, 3'd6, 3'd3, 3'd2});
    test_reset_mid();
    test_pairs(3'd1, {3'd5, 3'd4, 3'd1, 3'd0}, {3'd7, 3'd6, 3'd3, 3'd2});
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
